// File: rtl/lane_density_estimator.sv
// Four-lane detector conditioning: 2-flop sync, debounce, windowed arrival count,
// and quantisation to 2-bit congestion levels held stable for a full window.
module lane_density_estimator #(
  parameter int WINDOW_CYCLES   = 1000,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8,
  parameter int TH1             = 2,
  parameter int TH2             = 5,
  parameter int TH3             = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       det_a,
  input  logic       det_b,
  input  logic       det_c,
  input  logic       det_d,
  output logic [1:0] Sa,
  output logic [1:0] Sb,
  output logic [1:0] Sc,
  output logic [1:0] Sd,
  output logic       window_done
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int WIN_W = $clog2(WINDOW_CYCLES);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] TH1_C    = CNT_W'(TH1);
  localparam logic [CNT_W-1:0] TH2_C    = CNT_W'(TH2);
  localparam logic [CNT_W-1:0] TH3_C    = CNT_W'(TH3);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic inc);
    if (inc && (c != CNT_MAX)) return c + CNT_W'(1);
    return c;
  endfunction

  function automatic logic [1:0] quantize(input logic [CNT_W-1:0] n);
    if (n < TH1_C) return 2'd0;
    if (n < TH2_C) return 2'd1;
    if (n < TH3_C) return 2'd2;
    return 2'd3;
  endfunction

  logic [3:0]            det_raw;
  logic [3:0]            sync_p0;
  logic [3:0]            sync_p1;
  logic [3:0]            clean;
  logic [3:0][DB_W-1:0]  db_cnt;
  logic [3:0][CNT_W-1:0] arr_cnt;
  logic [3:0][1:0]       level;
  logic [WIN_W-1:0]      win_cnt;

  logic [3:0]            commit;
  logic [3:0]            arrival;
  logic [3:0][CNT_W-1:0] arr_next;
  logic                  terminal;

  assign det_raw = {det_d, det_c, det_b, det_a};

  // Stage p2: debounce commit and arrival count including a same-edge arrival
  always_comb begin
    commit   = '0;
    arrival  = '0;
    arr_next = arr_cnt;
    terminal = (win_cnt == WIN_LAST);
    for (int i = 0; i < 4; i++) begin
      commit[i]   = (sync_p1[i] != clean[i]) && (db_cnt[i] == DB_LAST);
      arrival[i]  = commit[i] & sync_p1[i];
      arr_next[i] = sat_inc(arr_cnt[i], arrival[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0     <= '0;
      sync_p1     <= '0;
      clean       <= '0;
      db_cnt      <= '0;
      arr_cnt     <= '0;
      level       <= '0;
      win_cnt     <= '0;
      window_done <= 1'b0;
    end else begin
      // Stage p0/p1: two-flop synchroniser for the asynchronous detector lines
      sync_p0 <= det_raw;
      sync_p1 <= sync_p0;

      win_cnt     <= terminal ? '0 : win_cnt + WIN_W'(1);
      window_done <= terminal;

      for (int i = 0; i < 4; i++) begin
        if (sync_p1[i] == clean[i]) begin
          db_cnt[i] <= '0;
        end else if (commit[i]) begin
          clean[i]  <= sync_p1[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end

        // Stage p3: a terminal-edge arrival closes with the old window, new one starts at 0
        if (terminal) begin
          level[i]   <= quantize(arr_next[i]);
          arr_cnt[i] <= '0;
        end else begin
          arr_cnt[i] <= arr_next[i];
        end
      end
    end
  end

  assign Sa = level[0];
  assign Sb = level[1];
  assign Sc = level[2];
  assign Sd = level[3];

endmodule
